scan_display_mux: RTL and testbench

Parametrised time-multiplexed driver for common-anode/common-cathode seven-segment arrays with N digits. It scans one digit per slot, decodes a 4-bit hex nibble per digit to segments plus decimal point, and supports PWM brightness and leading-zero blanking. Display data is captured once per frame, so a refresh never shows a mix of old and new digits. It sits between the numeric datapath (counters, BCD converters) and the board's digit-select and segment pins. It succeeds the fixed 4-digit scan_display.

---
 rtl/scan_display_mux.sv | 133 +++++++++++++
 tb/tb_scan_display_mux.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/scan_display_mux.sv
`default_nettype none
// ============================================================================
// scan_display_mux : N-digit multiplexed 7-segment driver with hex decode,
//                    PWM brightness and leading-zero blanking.  Rev 1.0
// ============================================================================
module scan_display_mux #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned CLK_DIV        = 1024,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [DIGITS-1:0]     select,
  output logic [7:0]            segment,
  output logic                  frame_start
);

  localparam int unsigned   CNT_W     = $clog2(CLK_DIV);
  localparam int unsigned   IDX_W     = $clog2(DIGITS);
  localparam logic [CNT_W:0] SLOT_UNIT = (CNT_W+1)'(CLK_DIV / 16);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   dig_sh_q, dig_sh_d;
  logic [DIGITS-1:0]     dp_sh_q, dp_sh_d;
  logic                  blz_sh_q, blz_sh_d;
  logic                  en_prev_q, en_prev_d;
  logic [DIGITS-1:0]     select_q, select_d;
  logic [7:0]            segment_q, segment_d;
  logic                  frame_start_q, frame_start_d;

  logic                  tick, wrap, pwm_on, zero_above, cur_dp, cur_blank;
  logic [3:0]            cur_nib;
  logic [CNT_W:0]        on_thr;
  logic [DIGITS-1:0]     sel_raw;
  logic [7:0]            seg_raw;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Current-digit view of the shadow data; blanking scans from the top digit down
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    zero_above = 1'b1;
    sel_raw    = '0;
    on_thr     = ({{(CNT_W-3){1'b0}}, brightness} + (CNT_W+1)'(1)) * SLOT_UNIT;
    pwm_on     = ({1'b0, cnt_q} < on_thr);
    for (int i = DIGITS-1; i >= 0; i--) begin
      zero_above = zero_above && (dig_sh_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_nib    = dig_sh_q[4*i +: 4];
        cur_dp     = dp_sh_q[i];
        cur_blank  = blz_sh_q && (i != 0) && zero_above;
        sel_raw[i] = pwm_on;
      end
    end
    seg_raw = {cur_dp, cur_blank ? 7'h00 : hex7(cur_nib)};
  end

  always_comb begin
    tick      = (cnt_q == CNT_W'(CLK_DIV - 1));
    wrap      = tick && (idx_q == IDX_W'(DIGITS - 1));
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dig_sh_d  = dig_sh_q;
    dp_sh_d   = dp_sh_q;
    blz_sh_d  = blz_sh_q;
    en_prev_d = en;
    if (!en) begin
      cnt_d    = '0;
      idx_d    = '0;
      dig_sh_d = digits_i;
      dp_sh_d  = dp_i;
      blz_sh_d = blank_lz;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
      if (wrap) begin
        dig_sh_d = digits_i;
        dp_sh_d  = dp_i;
        blz_sh_d = blank_lz;
      end
    end
    select_d      = (en ? sel_raw : '0) ^ {DIGITS{SEL_ACTIVE_LOW}};
    segment_d     = (en ? seg_raw : 8'h00) ^ {8{SEG_ACTIVE_LOW}};
    // A fresh frame starts after a wrap or after the scan is re-enabled
    frame_start_d = en && (wrap || !en_prev_q) && !frame_start_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      dig_sh_q      <= '0;
      dp_sh_q       <= '0;
      blz_sh_q      <= 1'b0;
      en_prev_q     <= 1'b0;
      select_q      <= {DIGITS{SEL_ACTIVE_LOW}};
      segment_q     <= {8{SEG_ACTIVE_LOW}};
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      dig_sh_q      <= dig_sh_d;
      dp_sh_q       <= dp_sh_d;
      blz_sh_q      <= blz_sh_d;
      en_prev_q     <= en_prev_d;
      select_q      <= select_d;
      segment_q     <= segment_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign select      = select_q;
  assign segment     = segment_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_display_mux.sv
`default_nettype none
// Scoreboard bench: a frame-position model predicts outputs for two DUTs
// (plain and inverted polarity) driven by the same stimulus.
module tb_scan_display_mux;
  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 16;
  localparam int FRAME   = DIGITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, blank_lz = 1'b0;
  logic [15:0] digits_i = 16'h0;
  logic [3:0]  dp_i = 4'h0, brightness = 4'hF;
  logic [3:0]  sel0, sel1;
  logic [7:0]  seg0, seg1;
  logic        fs0, fs1;

  always #5 clk = ~clk;

  scan_display_mux #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .digits_i(digits_i), .dp_i(dp_i), .blank_lz(blank_lz),
    .brightness(brightness), .select(sel0), .segment(seg0), .frame_start(fs0));

  scan_display_mux #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .digits_i(digits_i), .dp_i(dp_i), .blank_lz(blank_lz),
    .brightness(brightness), .select(sel1), .segment(seg1), .frame_start(fs1));

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model state: position within the frame plus captured display data
  int          t = 0;
  logic [15:0] m_dig = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic        m_blz = 1'b0, m_en_prev = 1'b0, m_fs_prev = 1'b0;
  logic [6:0]  segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic model_step(output exp_t e);
    int         d, s;
    logic       on, blank;
    logic [3:0] nib;
    e = '0;
    if (rst) begin
      t = 0; m_dig = '0; m_dp = '0; m_blz = 1'b0; m_en_prev = 1'b0; m_fs_prev = 1'b0;
    end else if (!en) begin
      t = 0; m_dig = digits_i; m_dp = dp_i; m_blz = blank_lz; m_en_prev = 1'b0; m_fs_prev = 1'b0;
    end else begin
      d     = t / CLK_DIV;
      s     = t % CLK_DIV;
      on    = s < ((int'(brightness) + 1) * CLK_DIV) / 16;
      nib   = 4'(m_dig >> (4 * d));
      blank = m_blz && (d >= 1) && ((m_dig >> (4 * d)) == 16'h0);
      e.sel = on ? 4'(1 << d) : 4'h0;
      e.seg = {m_dp[d], blank ? 7'h00 : segtab[nib]};
      e.fs  = (!m_en_prev || t == FRAME - 1) && !m_fs_prev;
      m_fs_prev = e.fs;
      m_en_prev = 1'b1;
      if (t == FRAME - 1) begin
        t = 0; m_dig = digits_i; m_dp = dp_i; m_blz = blank_lz;
      end else begin
        t++;
      end
    end
  endtask

  task automatic cycle(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      model_step(e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        chk("select_pol0",  {4'h0, sel0}, {4'h0, e.sel});
        chk("segment_pol0", seg0, e.seg);
        chk("fs_pol0",      {7'h0, fs0}, {7'h0, e.fs});
        chk("select_pol1",  {4'h0, sel1}, {4'h0, ~e.sel});
        chk("segment_pol1", seg1, ~e.seg);
        chk("fs_pol1",      {7'h0, fs1}, {7'h0, e.fs});
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [15:0] v;
    cycle(2);
    rst = 1'b0;
    digits_i = 16'h12AF; dp_i = 4'h0; brightness = 4'hF; blank_lz = 1'b0;
    cycle(2);
    en = 1'b1;
    cycle(2 * FRAME + 5);
    brightness = 4'd3;
    cycle(FRAME);
    brightness = 4'hF; blank_lz = 1'b1; digits_i = 16'h0070; dp_i = 4'b1000;
    cycle(2 * FRAME);
    digits_i = 16'h0000;
    cycle(2 * FRAME);
    blank_lz = 1'b0; dp_i = 4'h0; digits_i = 16'h1111;
    cycle(FRAME);
    while (t / CLK_DIV != 1) cycle(1);
    cycle(3);
    digits_i = 16'h2222;
    cycle(2 * FRAME);
    cycle(7);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    cycle(FRAME + 10);
    while (t / CLK_DIV != 2) cycle(1);
    en = 1'b0;
    cycle(5);
    digits_i = 16'h3456;
    en = 1'b1;
    cycle(FRAME + 3);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        v = 16'($urandom);
        for (int n = 0; n < 4; n++) if ($urandom_range(0, 1) == 0) v[4*n +: 4] = 4'h0;
        digits_i = v;
        dp_i     = 4'($urandom);
        blank_lz = 1'($urandom);
      end
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 99) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      rst = ($urandom_range(0, 399) == 0);
      cycle(1);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
